// File: rtl/bitwise_rtp_module.sv
// RTP packetiser: emits a 12-byte RTP header, then packs a serial MSB-first bit stream into bytes.
// Build option: define BITWISE_RTP_ZERO_PAD_EN to emit a final partial byte left-aligned and zero-padded.

module bitwise_rtp_module #(
   parameter logic [6:0]  PAYLOAD_TYPE = 7'd96,
   parameter logic [31:0] SSRC         = 32'h1234_5678,
   parameter logic [15:0] SEQ_INIT     = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_in,
   input  logic        data_valid_in,
   input  logic        prepare_for_data,
   input  logic [15:0] payload_size,
   input  logic [31:0] rtp_timestamp,
   input  logic        rtp_marker_in,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        ready_for_data,
   output logic        send_out
);

   // state    | meaning
   // ---------+------------------------------------------------------------
   // S_IDLE   | waiting for prepare_for_data; outputs quiet
   // S_HEADER | streaming header bytes 1..11 (byte 0 leaves on the start edge)
   // S_PAYLOAD| ready_for_data high; packing accepted bits into bytes
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_HEADER  = 2'd1;
   localparam logic [1:0] S_PAYLOAD = 2'd2;

   logic [1:0]  state;
   logic [15:0] seq;
   logic [15:0] bits_left;
   logic [31:0] ts_q;
   logic        marker_q;
   logic [3:0]  hdr_left;
   logic [2:0]  bit_pos;
   logic [7:0]  byte_q;

   logic [3:0]  hdr_idx;
   logic [7:0]  hdr_byte;
   logic [7:0]  byte_next;
   logic [7:0]  pad_byte;
   logic        byte_full;
   logic        last_bit;
   logic        emit_pad;

   // hdr_left counts down the header bytes still owed; index 0 is sent on the start edge
   assign hdr_idx = 4'd12 - hdr_left;

   always_comb begin
      hdr_byte = 8'h00;
      case (hdr_idx)
         4'd0:    hdr_byte = 8'h80;
         4'd1:    hdr_byte = {marker_q, PAYLOAD_TYPE};
         4'd2:    hdr_byte = seq[15:8];
         4'd3:    hdr_byte = seq[7:0];
         4'd4:    hdr_byte = ts_q[31:24];
         4'd5:    hdr_byte = ts_q[23:16];
         4'd6:    hdr_byte = ts_q[15:8];
         4'd7:    hdr_byte = ts_q[7:0];
         4'd8:    hdr_byte = SSRC[31:24];
         4'd9:    hdr_byte = SSRC[23:16];
         4'd10:   hdr_byte = SSRC[15:8];
         4'd11:   hdr_byte = SSRC[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   assign byte_next = {byte_q[6:0], data_in};
   assign byte_full = (bit_pos == 3'd7);
   assign last_bit  = (bits_left == 16'd1);

`ifdef BITWISE_RTP_ZERO_PAD_EN
   // only the bit_pos+1 low bits are fresh; shifting left drops stale bits of the previous byte
   assign emit_pad = last_bit && !byte_full;
   assign pad_byte = byte_next << (3'd7 - bit_pos);
`else
   assign emit_pad = 1'b0;
   assign pad_byte = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         seq            <= SEQ_INIT;
         bits_left      <= 16'd0;
         ts_q           <= 32'd0;
         marker_q       <= 1'b0;
         hdr_left       <= 4'd0;
         bit_pos        <= 3'd0;
         byte_q         <= 8'h00;
         data_out       <= 8'h00;
         valid_out      <= 1'b0;
         ready_for_data <= 1'b0;
         send_out       <= 1'b0;
      end else begin
         send_out  <= 1'b0;
         valid_out <= 1'b0;
         data_out  <= 8'h00;
         case (state)
            S_IDLE: begin
               if (prepare_for_data) begin
                  state     <= S_HEADER;
                  send_out  <= 1'b1;
                  valid_out <= 1'b1;
                  data_out  <= 8'h80;
                  hdr_left  <= 4'd11;
                  bits_left <= payload_size;
                  ts_q      <= rtp_timestamp;
                  marker_q  <= rtp_marker_in;
                  bit_pos   <= 3'd0;
                  byte_q    <= 8'h00;
               end
            end
            S_HEADER: begin
               if (hdr_left != 4'd0) begin
                  valid_out <= 1'b1;
                  data_out  <= hdr_byte;
                  hdr_left  <= hdr_left - 4'd1;
               end else if (bits_left == 16'd0) begin
                  state <= S_IDLE;
                  seq   <= seq + 16'd1;
               end else begin
                  state          <= S_PAYLOAD;
                  ready_for_data <= 1'b1;
               end
            end
            S_PAYLOAD: begin
               if (data_valid_in) begin
                  byte_q    <= byte_next;
                  bit_pos   <= bit_pos + 3'd1;
                  bits_left <= bits_left - 16'd1;
                  if (byte_full) begin
                     valid_out <= 1'b1;
                     data_out  <= byte_next;
                  end else if (emit_pad) begin
                     valid_out <= 1'b1;
                     data_out  <= pad_byte;
                  end
                  if (last_bit) begin
                     state          <= S_IDLE;
                     ready_for_data <= 1'b0;
                     seq            <= seq + 16'd1;
                  end
               end
            end
            default: begin
               state          <= S_IDLE;
               ready_for_data <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitwise_rtp_module.sv
// Directed bench for bitwise_rtp_module; expectations follow the default parameters.
// Honours BITWISE_RTP_ZERO_PAD_EN for the partial-byte case.

module tb_bitwise_rtp_module;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_in;
   logic        data_valid_in;
   logic        prepare_for_data;
   logic [15:0] payload_size;
   logic [31:0] rtp_timestamp;
   logic        rtp_marker_in;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        ready_for_data;
   logic        send_out;

   always #5 clk = ~clk;

   bitwise_rtp_module dut (
      .clk              (clk),
      .rst              (rst),
      .data_in          (data_in),
      .data_valid_in    (data_valid_in),
      .prepare_for_data (prepare_for_data),
      .payload_size     (payload_size),
      .rtp_timestamp    (rtp_timestamp),
      .rtp_marker_in    (rtp_marker_in),
      .data_out         (data_out),
      .valid_out        (valid_out),
      .ready_for_data   (ready_for_data),
      .send_out         (send_out)
   );

   int tests = 0;
   int fails = 0;

   logic [7:0] byte_q[$];
   int send_cnt = 0;
   int idle_bad = 0;

   always @(negedge clk) begin
      if (valid_out) byte_q.push_back(data_out);
      else if (data_out !== 8'h00) idle_bad++;
      if (send_out) send_cnt++;
   end

   logic       pat [0:1023];
   logic [7:0] exp_pay [0:127];
   int base, send_base, first_ready, ready_gap, bits_fed;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] qb(input int i);
      if (i < byte_q.size()) return byte_q[i];
      return 8'hxx;
   endfunction

   task automatic fill_ones(input int n);
      for (int i = 0; i < n; i++) pat[i] = 1'b1;
      for (int i = 0; i < n / 8; i++) exp_pay[i] = 8'hFF;
   endtask

   task automatic fill_from_bytes(input int nbytes);
      for (int i = 0; i < nbytes; i++)
         for (int j = 0; j < 8; j++) pat[i*8+j] = exp_pay[i][7-j];
   endtask

   task automatic run_packet(input int size, input logic [31:0] ts, input logic mk,
                             input bit stall, input bit junk, input int abort_at);
      int idx;
      int cyc;
      bit drove;
      base        = byte_q.size();
      send_base   = send_cnt;
      first_ready = -1;
      ready_gap   = 0;
      idx         = 0;
      payload_size     = size[15:0];
      rtp_timestamp    = ts;
      rtp_marker_in    = mk;
      prepare_for_data = 1'b1;
      data_valid_in    = 1'b0;
      data_in          = 1'b0;
      tick;
      cyc = 1;
      chk("start_send", {31'd0, send_out}, 32'd1);
      chk("start_valid", {31'd0, valid_out}, 32'd1);
      chk("start_byte", {24'd0, data_out}, 32'h80);
      for (int n = 0; n < 12 + size * 2 + 6; n++) begin
         if (abort_at >= 0 && idx == abort_at) break;
         drove = 1'b0;
         if (ready_for_data) begin
            if (first_ready < 0) first_ready = cyc;
            if (idx < size && !(stall && (cyc % 2 == 1))) begin
               data_valid_in = 1'b1;
               data_in       = pat[idx];
               drove         = 1'b1;
            end else begin
               data_valid_in = 1'b0;
               data_in       = 1'b0;
            end
         end else begin
            if (idx > 0 && idx < size) ready_gap++;
            data_valid_in = junk;
            data_in       = 1'b0;
         end
         prepare_for_data = junk && (idx < size);
         tick;
         cyc++;
         if (drove) idx++;
         if (cyc == 2) chk("send_one_cycle", {31'd0, send_out}, 32'd0);
      end
      data_valid_in    = 1'b0;
      prepare_for_data = 1'b0;
      bits_fed         = idx;
   endtask

   task automatic check_header(input string tag, input logic mk, input logic [15:0] sq,
                               input logic [31:0] ts);
      chk({tag, "_h0"},  {24'd0, qb(base+0)},  32'h80);
      chk({tag, "_h1"},  {24'd0, qb(base+1)},  {24'd0, mk, 7'h60});
      chk({tag, "_h2"},  {24'd0, qb(base+2)},  {24'd0, sq[15:8]});
      chk({tag, "_h3"},  {24'd0, qb(base+3)},  {24'd0, sq[7:0]});
      chk({tag, "_h4"},  {24'd0, qb(base+4)},  {24'd0, ts[31:24]});
      chk({tag, "_h5"},  {24'd0, qb(base+5)},  {24'd0, ts[23:16]});
      chk({tag, "_h6"},  {24'd0, qb(base+6)},  {24'd0, ts[15:8]});
      chk({tag, "_h7"},  {24'd0, qb(base+7)},  {24'd0, ts[7:0]});
      chk({tag, "_h8"},  {24'd0, qb(base+8)},  32'h12);
      chk({tag, "_h9"},  {24'd0, qb(base+9)},  32'h34);
      chk({tag, "_h10"}, {24'd0, qb(base+10)}, 32'h56);
      chk({tag, "_h11"}, {24'd0, qb(base+11)}, 32'h78);
   endtask

   task automatic check_payload(input string tag, input int n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_p%0d", tag, i), {24'd0, qb(base+12+i)}, {24'd0, exp_pay[i]});
   endtask

   initial begin
      rst              = 1'b1;
      data_in          = 1'b0;
      data_valid_in    = 1'b0;
      prepare_for_data = 1'b0;
      payload_size     = 16'd0;
      rtp_timestamp    = 32'd0;
      rtp_marker_in    = 1'b0;
      repeat (3) tick;
      chk("rst_send",  {31'd0, send_out},       32'd0);
      chk("rst_valid", {31'd0, valid_out},      32'd0);
      chk("rst_ready", {31'd0, ready_for_data}, 32'd0);
      chk("rst_data",  {24'd0, data_out},       32'd0);
      rst = 1'b0;
      tick;

      // basic 512-bit packet, all ones
      fill_ones(512);
      run_packet(512, 32'd200, 1'b1, 1'b0, 1'b0, -1);
      chk("p1_sends", send_cnt - send_base, 32'd1);
      chk("p1_count", byte_q.size() - base, 32'd76);
      chk("p1_ready_cycle", first_ready, 32'd13);
      chk("p1_bits", bits_fed, 32'd512);
      check_header("p1", 1'b1, 16'h0000, 32'd200);
      check_payload("p1", 64);

      // identical packet: sequence advances
      run_packet(512, 32'd200, 1'b1, 1'b0, 1'b0, -1);
      chk("p2_count", byte_q.size() - base, 32'd76);
      check_header("p2", 1'b1, 16'h0001, 32'd200);

      // bit order, with prepare/data_valid_in junk outside their windows
      exp_pay[0] = 8'hAA;
      exp_pay[1] = 8'h0F;
      fill_from_bytes(2);
      run_packet(16, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b1, -1);
      chk("p3_sends", send_cnt - send_base, 32'd1);
      chk("p3_count", byte_q.size() - base, 32'd14);
      check_header("p3", 1'b0, 16'h0002, 32'hA1B2C3D4);
      check_payload("p3", 2);

      // stalls on alternate cycles
      exp_pay[0] = 8'hDE;
      exp_pay[1] = 8'hAD;
      exp_pay[2] = 8'hBE;
      exp_pay[3] = 8'hEF;
      fill_from_bytes(4);
      run_packet(32, 32'h0000_0010, 1'b1, 1'b1, 1'b0, -1);
      chk("p4_ready_gap", ready_gap, 32'd0);
      chk("p4_bits", bits_fed, 32'd32);
      chk("p4_count", byte_q.size() - base, 32'd16);
      check_header("p4", 1'b1, 16'h0003, 32'h0000_0010);
      check_payload("p4", 4);

      // reset after 20 payload bits
      fill_ones(64);
      run_packet(64, 32'd5, 1'b0, 1'b0, 1'b0, 20);
      chk("p5_bits", bits_fed, 32'd20);
      rst = 1'b1;
      tick;
      chk("p5_rst_send",  {31'd0, send_out},       32'd0);
      chk("p5_rst_valid", {31'd0, valid_out},      32'd0);
      chk("p5_rst_ready", {31'd0, ready_for_data}, 32'd0);
      chk("p5_rst_data",  {24'd0, data_out},       32'd0);
      rst = 1'b0;
      repeat (4) tick;
      chk("p5_abandoned", byte_q.size() - base, 32'd14);

      // 12-bit payload: partial byte handling; seq restarted by reset
      fill_ones(12);
      run_packet(12, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, -1);
      check_header("p6", 1'b0, 16'h0000, 32'h0BAD_F00D);
`ifdef BITWISE_RTP_ZERO_PAD_EN
      exp_pay[1] = 8'hF0;
      chk("p6_count", byte_q.size() - base, 32'd14);
      check_payload("p6", 2);
`else
      chk("p6_count", byte_q.size() - base, 32'd13);
      check_payload("p6", 1);
`endif

      // zero-length payload: header only, still advances seq
      run_packet(0, 32'd7, 1'b1, 1'b0, 1'b0, -1);
      chk("p7_count", byte_q.size() - base, 32'd12);
      chk("p7_no_ready", first_ready, 32'hFFFF_FFFF);
      check_header("p7", 1'b1, 16'h0001, 32'd7);

      exp_pay[0] = 8'hAA;
      exp_pay[1] = 8'h0F;
      fill_from_bytes(2);
      run_packet(16, 32'd9, 1'b0, 1'b0, 1'b0, -1);
      chk("p8_count", byte_q.size() - base, 32'd14);
      check_header("p8", 1'b0, 16'h0002, 32'd9);
      check_payload("p8", 2);

      chk("idle_data_zero", idle_bad, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bitwise_rtp_module.md
BITWISE_RTP_MODULE -- requirements
Module: bitwise_rtp_module

Interface
REQ-001 SHALL have parameter PAYLOAD_TYPE, default 96, the 7-bit RTP payload type.
REQ-002 SHALL have parameter SSRC, default 32'h1234_5678, the RTP synchronization source.
REQ-003 SHALL have parameter SEQ_INIT, default 16'h0000, the sequence number after reset.
REQ-004 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data_in, input, 1, payload bit, sent MSB-first per byte.
REQ-007 SHALL have port data_valid_in, input, 1, qualifies data_in.
REQ-008 SHALL have port prepare_for_data, input, 1, one-cycle request to start a packet.
REQ-009 SHALL have port payload_size, input, 16, payload length in bits.
REQ-010 SHALL have port rtp_timestamp, input, 32, RTP timestamp for the packet.
REQ-011 SHALL have port rtp_marker_in, input, 1, RTP marker bit for the packet.
REQ-012 SHALL have port data_out, output, 8, byte to the MAC.
REQ-013 SHALL have port valid_out, output, 1, qualifies data_out for one cycle per byte.
REQ-014 SHALL have port ready_for_data, output, 1, high while payload bits are accepted.
REQ-015 SHALL have port send_out, output, 1, one-cycle frame-start pulse to the MAC.

Function
REQ-016 SHALL implement states IDLE, HEADER, PAYLOAD.
REQ-017 In IDLE, prepare_for_data=1 at edge T SHALL latch payload_size, rtp_timestamp and rtp_marker_in, and enter HEADER.
REQ-018 SHALL hold send_out=1 only in cycle T+1.
REQ-019 SHALL emit the 12 header bytes in cycles T+1..T+12 with valid_out=1 in order: 0x80, {marker,PAYLOAD_TYPE[6:0]}, seq[15:8], seq[7:0], timestamp MSB..LSB, SSRC MSB..LSB.
REQ-020 SHALL enter PAYLOAD in cycle T+13 with ready_for_data=1 registered.
REQ-021 In PAYLOAD, SHALL shift data_in into bit 0 of a byte register on each cycle with data_valid_in=1; cycles with data_valid_in=0 SHALL consume nothing.
REQ-022 When the 8th bit of a byte is accepted at edge C, SHALL present that byte with valid_out=1 during cycle C+1 only.
REQ-023 When bit number payload_size is accepted at edge C, SHALL drop ready_for_data, return to IDLE and increment seq modulo 2^16 in cycle C+1.
REQ-024 SHALL accept prepare_for_data again from cycle C+1.
REQ-025 SHALL ignore prepare_for_data outside IDLE.
REQ-026 SHALL ignore data_valid_in outside PAYLOAD.
REQ-027 With payload_size=0, SHALL return to IDLE after the header, never assert ready_for_data, and still increment seq.
REQ-028 SHALL hold valid_out=0 and data_out=0x00 in every cycle not carrying a byte.

Reset
REQ-029 rst SHALL force state=IDLE, send_out=0, valid_out=0, ready_for_data=0, data_out=0x00, clear bit and byte counters, and set seq=SEQ_INIT.
REQ-030 rst SHALL take priority over all inputs, and a packet interrupted by rst SHALL be abandoned without completion.

Configuration
REQ-031 With macro BITWISE_RTP_ZERO_PAD_EN defined, a payload_size not a multiple of 8 SHALL have its final partial byte left-aligned, zero-padded and emitted in the cycle after its last bit.
REQ-032 Without BITWISE_RTP_ZERO_PAD_EN, trailing partial-byte bits SHALL be discarded, and only floor(payload_size/8) payload bytes SHALL be emitted.

Verification
REQ-033 Basic packet: SSRC default, seq=0, rtp_timestamp=200, marker=1, payload_size=512, data_in=1 continuous -> one send_out pulse; 76 valid bytes: 80 E0 00 00 00 00 00 C8 12 34 56 78, then 64 x FF.
REQ-034 Second identical packet -> seq bytes 00 01.
REQ-035 Bit order: payload_size=16, bits 1,0,1,0,... then 0,0,0,0,1,1,1,1 -> payload bytes AA 0F.
REQ-036 Stall: 32-bit payload with data_valid_in low every other cycle -> same 4 bytes, ready_for_data high throughout until the last bit.
REQ-037 Reset mid-payload after 20 bits -> all outputs 0 next cycle; next packet carries seq=SEQ_INIT.
REQ-038 payload_size=12, bits all 1: with BITWISE_RTP_ZERO_PAD_EN -> payload FF F0; without -> payload FF only.
